// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    StStart,
    StEmpty,
    StFull,
    StSkidf
  } state_e;

  localparam logic [31:0] DISCARD_PC_DEFAULT = 32'hFFFF_FF00;

  function automatic logic [1:0] state_occupancy(state_e s);
    case (s)
      StFull:  return 2'd1;
      StSkidf: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One stage payload register {pc4, data, have_inst} with load, clear-to-discard and hold.
module pipe_slot #(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     DATA_W     = 32,
  parameter logic [PC_W-1:0] DISCARD_PC = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc4_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              have_inst_i,
  output logic [PC_W-1:0]   pc4_o,
  output logic [DATA_W-1:0] data_o,
  output logic              have_inst_o
);

  logic [PC_W-1:0]   pc4_q;
  logic [DATA_W-1:0] data_q;
  logic              have_inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc4_q       <= '0;
      data_q      <= '0;
      have_inst_q <= 1'b0;
    end else if (clear_i) begin
      pc4_q       <= DISCARD_PC;
      data_q      <= '0;
      have_inst_q <= 1'b0;
    end else if (load_i) begin
      pc4_q       <= pc4_i;
      data_q      <= data_i;
      have_inst_q <= have_inst_i;
    end
  end

  assign pc4_o       = pc4_q;
  assign data_o      = data_q;
  assign have_inst_o = have_inst_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// start bubble after reset and a flush that is deferred across a stall.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     DATA_W     = 32,
  parameter logic [PC_W-1:0] DISCARD_PC = PC_W'(DISCARD_PC_DEFAULT),
  parameter int unsigned     SKID       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   up_pc4_i,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic              up_have_inst_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   dn_pc4_o,
  output logic [DATA_W-1:0] dn_data_o,
  output logic              dn_have_inst_o,
  output logic [1:0]        occupancy_o
);

  state_e state_q, state_d;
  logic   flush_pend_q, flush_pend_d;
  logic   in_beat, out_beat;
  logic   main_load, main_sel_skid, slot_clear, skid_load;

  logic [PC_W-1:0]   skid_pc4, main_pc4_d;
  logic [DATA_W-1:0] skid_data, main_data_d;
  logic              skid_have_inst, main_have_inst_d;

  // With a skid buffer, ready is a function of registered state only.
  always_comb begin
    up_ready_o = 1'b0;
    if (!stall_i && !flush_i && !flush_pend_q) begin
      if (SKID != 0) begin
        up_ready_o = (state_q == StEmpty) || (state_q == StFull);
      end else begin
        up_ready_o = (state_q == StEmpty) || ((state_q == StFull) && dn_ready_i);
      end
    end
  end

  assign dn_valid_o  = (state_q == StFull) || (state_q == StSkidf);
  assign occupancy_o = state_occupancy(state_q);
  assign in_beat     = up_valid_i && up_ready_o;
  assign out_beat    = dn_valid_o && dn_ready_i && !stall_i;

  always_comb begin
    state_d       = state_q;
    flush_pend_d  = flush_pend_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    slot_clear    = 1'b0;
    skid_load     = 1'b0;
    if (state_q == StStart) begin
      state_d = StEmpty;
    end else if (stall_i) begin
      if (flush_i) flush_pend_d = 1'b1;
    end else if (flush_i || flush_pend_q) begin
      state_d      = StEmpty;
      flush_pend_d = 1'b0;
      slot_clear   = 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_beat) begin
            main_load = 1'b1;
            state_d   = StFull;
          end
        end
        StFull: begin
          if (in_beat && out_beat) begin
            main_load = 1'b1;
          end else if (in_beat) begin
            skid_load = 1'b1;
            state_d   = StSkidf;
          end else if (out_beat) begin
            state_d = StEmpty;
          end
        end
        StSkidf: begin
          if (out_beat) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            state_d       = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StStart;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign main_pc4_d       = main_sel_skid ? skid_pc4       : up_pc4_i;
  assign main_data_d      = main_sel_skid ? skid_data      : up_data_i;
  assign main_have_inst_d = main_sel_skid ? skid_have_inst : up_have_inst_i;

  pipe_slot #(
    .PC_W       (PC_W),
    .DATA_W     (DATA_W),
    .DISCARD_PC (DISCARD_PC)
  ) u_main (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (main_load),
    .clear_i     (slot_clear),
    .pc4_i       (main_pc4_d),
    .data_i      (main_data_d),
    .have_inst_i (main_have_inst_d),
    .pc4_o       (dn_pc4_o),
    .data_o      (dn_data_o),
    .have_inst_o (dn_have_inst_o)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .PC_W       (PC_W),
      .DATA_W     (DATA_W),
      .DISCARD_PC (DISCARD_PC)
    ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (skid_load),
      .clear_i     (slot_clear),
      .pc4_i       (up_pc4_i),
      .data_i      (up_data_i),
      .have_inst_i (up_have_inst_i),
      .pc4_o       (skid_pc4),
      .data_o      (skid_data),
      .have_inst_o (skid_have_inst)
    );
  end else begin : g_no_skid
    assign skid_pc4       = '0;
    assign skid_data      = '0;
    assign skid_have_inst = 1'b0;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue-based stage model predicts acceptance and
// occupancy, and a separate monitor checks every delivered beat against the expected queue.
module tb_pipe_stage_skid;

  localparam logic [31:0] DISCARD = 32'hFFFF_FF00;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] data;
    logic        have;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        up_valid_i = 1'b0, up_ready_o;
  logic [31:0] up_pc4_i = '0, up_data_i = '0;
  logic        up_have_inst_i = 1'b0;
  logic        dn_valid_o, dn_ready_i = 1'b0;
  logic [31:0] dn_pc4_o, dn_data_o;
  logic        dn_have_inst_o;
  logic [1:0]  occupancy_o;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PC_W       (32),
    .DATA_W     (32),
    .DISCARD_PC (DISCARD),
    .SKID       (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .up_valid_i     (up_valid_i),
    .up_ready_o     (up_ready_o),
    .up_pc4_i       (up_pc4_i),
    .up_data_i      (up_data_i),
    .up_have_inst_i (up_have_inst_i),
    .dn_valid_o     (dn_valid_o),
    .dn_ready_i     (dn_ready_i),
    .dn_pc4_o       (dn_pc4_o),
    .dn_data_o      (dn_data_o),
    .dn_have_inst_o (dn_have_inst_o),
    .occupancy_o    (occupancy_o)
  );

  int    n_checks = 0;
  int    n_pass = 0;
  beat_t exp_q[$];
  int    cnt = 0;         // beats held by the modelled stage
  bit    pend = 1'b0;     // modelled deferred flush
  bit    flushed_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_state();
    chk("dn_valid", 64'(dn_valid_o), 64'(cnt > 0));
    chk("occupancy", 64'(occupancy_o), 64'(cnt));
    if (flushed_exp) begin
      chk("flush_pc4", 64'(dn_pc4_o), 64'(DISCARD));
      chk("flush_data", 64'(dn_data_o), 64'd0);
      chk("flush_have", 64'(dn_have_inst_o), 64'd0);
    end
  endtask

  // One cycle: check post-edge state, drive inputs, then advance the model for the next edge.
  task automatic step(input bit v, input logic [31:0] pc, input bit dnr, input bit st,
                      input bit fl);
    beat_t b;
    bit    rdy, in_b, out_b;
    @(negedge clk);
    check_state();
    b.pc4  = pc;
    b.data = $urandom;
    b.have = 1'($urandom_range(0, 1));
    if (fl || pend) dnr = 1'b0;  // a beat under flush is discarded, never consumed
    up_valid_i     = v;
    up_pc4_i       = b.pc4;
    up_data_i      = b.data;
    up_have_inst_i = b.have;
    dn_ready_i     = dnr;
    stall_i        = st;
    flush_i        = fl;
    rdy = !st && !fl && !pend && (cnt < 2);
    #1;
    chk("up_ready", 64'(up_ready_o), 64'(rdy));
    if (st) begin
      if (fl) pend = 1'b1;
    end else if (fl || pend) begin
      cnt = 0;
      exp_q.delete();
      pend = 1'b0;
      flushed_exp = 1'b1;
    end else begin
      out_b = (cnt > 0) && dnr;
      in_b  = v && rdy;
      if (out_b) cnt--;
      if (in_b) begin
        cnt++;
        exp_q.push_back(b);
        flushed_exp = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every downstream transfer, just before the edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && dn_valid_o && dn_ready_i && !stall_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got pc4 %0h, expected no beat", dn_pc4_o);
        end else begin
          e = exp_q.pop_front();
          chk("dn_pc4", 64'(dn_pc4_o), 64'(e.pc4));
          chk("dn_data", 64'(dn_data_o), 64'(e.data));
          chk("dn_have", 64'(dn_have_inst_o), 64'(e.have));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(dn_valid_o), 64'd0);
    chk("rst_pc4", 64'(dn_pc4_o), 64'd0);
    chk("rst_data", 64'(dn_data_o), 64'd0);
    chk("rst_have", 64'(dn_have_inst_o), 64'd0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_ready", 64'(up_ready_o), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("start_ready", 64'(up_ready_o), 64'd0);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(4 * i), 1'b1, 1'b0, 1'b0);
    drain();

    // One back-pressure cycle absorbed by the skid slot.
    step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1C, 1'b1, 1'b0, 1'b0);
    drain();

    // Stall holds contents and refuses upstream beats.
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("stall_hold_pc4", 64'(dn_pc4_o), 64'h20);
    drain();

    // Flush with a concurrent upstream beat.
    step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b0, 1'b1);
    drain();

    // Flush during stall with the skid full, applied on the first unstalled edge.
    step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h34, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end
    drain();
    drain();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-cycle discards contents immediately.
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(dn_valid_o), 64'd0);
    chk("async_rst_occ", 64'(occupancy_o), 64'd0);
    chk("async_rst_pc4", 64'(dn_pc4_o), 64'd0);
    chk("async_rst_ready", 64'(up_ready_o), 64'd0);
    exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the in-order core, placed between adjacent stages (IF/ID, ID/EX, …) in place of fixed-width per-stage latches. It carries a pc+4 field, a generic payload and a have-instruction debug flag. It adds a valid/ready handshake with an optional 2-entry skid buffer, and a deferred flush that survives a concurrent stall. It keeps the existing stage-register contract: a post-reset start bubble, stall holds contents, and flush inserts a bubble marked with a discard PC.

## Interface
Parameters:
- PC_W, 32, width of pc+4 field
- DATA_W, 32, payload width (instruction or decoded bundle)
- DISCARD_PC, 32'hFFFF_FF00, PC value presented on a flushed bubble
- SKID, 1, 1 = 2-entry skid buffer with registered ready; 0 = single entry, ready passes through

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hazard stall; freezes stage contents
- flush_i  in  1  branch/redirect flush request
- up_valid_i  in  1  upstream beat valid
- up_ready_o  out  1  stage can accept a beat
- up_pc4_i  in  PC_W  upstream pc+4
- up_data_i  in  DATA_W  upstream payload
- up_have_inst_i  in  1  upstream debug have-instruction flag
- dn_valid_o  out  1  main slot holds a valid beat
- dn_ready_i  in  1  downstream accepts
- dn_pc4_o  out  PC_W  main-slot pc+4
- dn_data_o  out  DATA_W  main-slot payload
- dn_have_inst_o  out  1  main-slot debug flag
- occupancy_o  out  2  entries held: 0, 1 or 2

## Operation
- Handshake terms:
  - in = up_valid_i & up_ready_o
  - out = dn_valid_o & dn_ready_i & !stall_i
  - Beats are never duplicated or reordered.
- State machine: START, EMPTY, FULL, SKIDF.
  - Reset enters START.
  - START lasts exactly one cycle, with up_ready_o=0, then goes to EMPTY.
  - EMPTY: in loads main, then FULL.
  - FULL, in & out: main <= up, stay FULL.
  - FULL, in & !out: skid <= up, then SKIDF. Only reachable when SKID=1.
  - FULL, !in & out: go to EMPTY.
  - SKIDF, out: main <= skid, then FULL. Incoming beats are impossible here because up_ready_o=0.
- up_ready_o:
  - SKID=1: !stall_i & !flush_pend & state∈{EMPTY,FULL}. There is no combinational path from dn_ready_i.
  - SKID=0: !stall_i & !flush_pend & (state==EMPTY | (state==FULL & dn_ready_i)).
- Stall: while stall_i=1 there is no in and no out. All slots, state and outputs hold. dn_valid_o stays as is.
- Flush: when flush_i=1 and stall_i=0, at the edge:
  - both slots are invalidated and state becomes EMPTY
  - dn_pc4_o <= DISCARD_PC, dn_data_o <= 0, dn_have_inst_o <= 0
  - any same-cycle upstream beat is dropped, and up_ready_o is forced to 0 that cycle
- Flush during stall: flush_i=1 with stall_i=1 sets flush_pend. The flush is applied on the first edge with stall_i=0. flush_pend clears on application.
- Priority: reset > START > stall > flush (flush_i or flush_pend) > handshake.
- In EMPTY, dn_pc4_o, dn_data_o and dn_have_inst_o hold their last values; only dn_valid_o drops.
- occupancy_o: 0 for START and EMPTY, 1 for FULL, 2 for SKIDF.

## Timing
- Reset and START values: dn_valid_o=0, dn_pc4_o=0, dn_data_o=0, dn_have_inst_o=0, occupancy_o=0, up_ready_o=0, flush_pend=0.
- Latency: a beat accepted at edge N appears on dn_* after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained when dn_ready_i=1.
- SKID=1: one downstream back-pressure cycle is absorbed without loss. up_ready_o falls in the cycle after the skid fills.
- Reset asserted mid-operation discards all contents, including skid and flush_pend, immediately (asynchronously).

## Structure
- Shared package pipe_pkg:
  - state enum (START, EMPTY, FULL, SKIDF)
  - default DISCARD_PC constant
- Sub-module pipe_slot: one payload register {pc4, data, have_inst} with load, clear-to-discard and hold. Instantiated once for main and once for skid; the skid instance is generated only when SKID=1.

## Test plan
- Reset, then first edge -> START: up_ready_o=0, all outputs 0. Second edge -> EMPTY, up_ready_o=1.
- Stream 4 beats (pc4 0x4, 0x8, 0xC, 0x10) with dn_ready_i=1 -> same sequence on dn_*, each 1 cycle after accept, occupancy_o=1 throughout.
- SKID=1, dn_ready_i=0 for 1 cycle mid-stream -> occupancy_o=2, up_ready_o=0 next cycle. No beat lost; order preserved when dn_ready_i returns.
- Hold stall_i=1 for 3 cycles with pc4=0x20 in main -> outputs and occupancy unchanged; up_valid_i beats not accepted.
- flush_i=1 with stall_i=0, main holding 0x24, up_valid_i=1 -> next cycle dn_valid_o=0, dn_pc4_o=0xFFFF_FF00, dn_data_o=0, occupancy_o=0; upstream beat dropped.
- flush_i pulse during stall_i=1, then stall_i drops 2 cycles later -> flush applied on the first unstalled edge: dn_pc4_o=DISCARD_PC, skid contents discarded.
